// File: rtl/gpio_apb_ctrl.sv
// APB3 slave front-end for one GPIO register block: times register reads,
// issues single-cycle write strobes and merges partial-strobe writes by read-modify-write.
module gpio_apb_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RD_WAIT    = 1,
    parameter int unsigned MAX_OFFSET = 32'h24
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [31:0]       gpio_addr,
    output logic [31:0]       gpio_dat_i,
    output logic              gpio_we,
    input  logic [31:0]       gpio_dat_o
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [31:0] prdata_nx, gpio_addr_nx, gpio_dat_i_nx, merged;
    logic        pready_nx, pslverr_nx, gpio_we_nx;
    logic        setup_err;

    // Offset 0x00 is the read-only input register, so writing it is illegal.
    assign setup_err = (paddr[1:0] != 2'b00) || (32'(paddr) > MAX_OFFSET) ||
                       (pwrite && (paddr == '0));

    // pwdata/pstrb are held stable by the APB master for the whole transfer.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[i*8 +: 8] = pstrb[i] ? pwdata[i*8 +: 8] : gpio_dat_o[i*8 +: 8];
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        prdata_nx     = prdata;
        gpio_addr_nx  = gpio_addr;
        gpio_dat_i_nx = gpio_dat_i;
        pready_nx     = 1'b0;
        pslverr_nx    = 1'b0;
        gpio_we_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    gpio_addr_nx = 32'(paddr);
                    if (setup_err) begin
                        state_nx   = RESP;
                        pready_nx  = 1'b1;
                        pslverr_nx = 1'b1;
                        prdata_nx  = '0;
                    end else if (!pwrite) begin
                        state_nx = RD;
                        cnt_nx   = 3'(RD_WAIT);
                    end else if (pstrb == 4'hF) begin
                        state_nx      = WR;
                        gpio_dat_i_nx = pwdata;
                        gpio_we_nx    = 1'b1;
                        pready_nx     = 1'b1;
                    end else if (pstrb == 4'h0) begin
                        state_nx  = RESP;
                        pready_nx = 1'b1;
                    end else begin
                        state_nx = RMW_RD;
                        cnt_nx   = 3'(RD_WAIT);
                    end
                end
            end
            RD, RMW_RD: begin
                // Only psel is watched mid-transfer; losing it abandons the access silently.
                if (!psel) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        pready_nx = 1'b1;
                        if (state == RD) begin
                            prdata_nx = gpio_dat_o;
                            state_nx  = RESP;
                        end else begin
                            gpio_dat_i_nx = merged;
                            gpio_we_nx    = 1'b1;
                            state_nx      = WR;
                        end
                    end
                end
            end
            WR, RESP: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            prdata     <= '0;
            gpio_addr  <= '0;
            gpio_dat_i <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            gpio_we    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            prdata     <= prdata_nx;
            gpio_addr  <= gpio_addr_nx;
            gpio_dat_i <= gpio_dat_i_nx;
            pready     <= pready_nx;
            pslverr    <= pslverr_nx;
            gpio_we    <= gpio_we_nx;
        end
    end

endmodule

// File: doc/gpio_apb_ctrl.md
Name: gpio_apb_ctrl

Overview:
- APB3 slave-side controller that sequences the GPIO register block over its simple sys-bus port (gpio_addr, gpio_dat_i, gpio_we, gpio_dat_o).
- Converts APB setup/access phases into timed register reads and single-cycle write strobes.
- Merges partial-strobe writes by read-modify-write, and flags illegal accesses with PSLVERR.
- Sits between the APB interconnect and the register block, with one instance per GPIO.

Parameters:
ADDR_W, 8, APB address width; only paddr[ADDR_W-1:0] is decoded.
RD_WAIT, 1, cycles between gpio_addr update and gpio_dat_o sampling; legal range 1..7.
MAX_OFFSET, 8'h24, highest valid word-aligned register offset.

Ports:
sys_clk  input  1  system clock; all state on rising edge
sys_rst  input  1  asynchronous, active-high reset
psel  input  1  APB select
penable  input  1  APB access phase
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_W  byte address
pwdata  input  32  write data
pstrb  input  4  byte lane strobes
prdata  output  32  read data, valid when pready=1 and pwrite=0
pready  output  1  transfer-complete pulse
pslverr  output  1  error, valid only with pready
gpio_addr  output  32  register offset to the register block; zero-extended paddr
gpio_dat_i  output  32  write data to the register block
gpio_we  output  1  register write strobe
gpio_dat_o  input  32  read data from the register block

Behaviour:
- Reset (async, on assertion): state IDLE, wait counter 0; prdata, gpio_addr, gpio_dat_i = 0; pready, pslverr, gpio_we = 0.
- Reset during a transfer aborts it immediately. gpio_we drops without waiting for a clock edge. No write is issued after release.
- All outputs are registered.
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: on a clock edge with psel=1 and penable=0 (setup), latch paddr into gpio_addr and classify the transfer.
  - Error, if paddr[1:0]!=0, or offset>MAX_OFFSET, or (pwrite=1 and offset==0x00, the read-only input register): go to RESP with pslverr=1, pready=1. No gpio_we. prdata=0.
  - Read: go to RD and load counter = RD_WAIT.
  - Write with pstrb=4'hF: go to WR, gpio_dat_i=pwdata, gpio_we=1, pready=1.
  - Write with pstrb=4'h0: go to RESP, pready=1, pslverr=0. No gpio_we.
  - Other write: go to RMW_RD and load counter = RD_WAIT.
- RD: decrement the counter each cycle. When it reaches 1, on that edge: prdata<=gpio_dat_o, pready<=1, go to RESP.
- Read latency: pready is high in access cycle RD_WAIT+1, i.e. RD_WAIT wait states.
- RMW_RD: count as in RD. On the final edge, for each byte lane: gpio_dat_i = pstrb[i] ? pwdata lane i : gpio_dat_o lane i. Set gpio_we=1 and pready=1, go to WR. The write costs RD_WAIT wait states.
- WR and RESP: last for exactly one cycle, then return to IDLE. pready, pslverr and gpio_we clear on that edge.
- gpio_we is high for exactly one cycle per accepted write, and always coincides with pready.
- gpio_addr and gpio_dat_i hold their last values between transfers. prdata holds its value until the next read completes.
- Back-to-back transfers: a setup phase in the cycle right after the pready cycle is accepted with no idle cycle.
- Protocol violation: if psel drops while in RD or RMW_RD, abort to IDLE. No gpio_we, no pready.
- penable is not re-checked during a transfer; only psel is monitored.

Test Plan:
1. Full write: APB write paddr=0x04, pwdata=32'habcd_ef12, pstrb=F -> gpio_we high exactly one cycle in the first access cycle, with gpio_addr=0x04 and gpio_dat_i=abcd_ef12; pready=1, pslverr=0; zero wait states.
2. Read (RD_WAIT=1): paddr=0x04 with register returning abcd_ef12 -> pready in the second access cycle, prdata=abcd_ef12, pslverr=0, gpio_we stays 0.
3. RMW: with the register holding abcd_ef12, write paddr=0x08, pwdata=32'h1111_2222, pstrb=4'b0101 -> single gpio_we pulse with gpio_dat_i=32'habcd_2222... correction: byte lanes 0 and 2 from pwdata gives 32'hab11_ef22; one wait state.
4. Errors: write to 0x00, read of 0x28, and access to 0x05 -> each gives pready=1 and pslverr=1 in the first access cycle, no gpio_we, prdata=0.
5. Back-to-back and pstrb=0: write 0x14 immediately followed by read 0x14 -> both complete and the read returns the written value. A write with pstrb=0 -> pready with no gpio_we.
6. Reset mid-RMW: assert sys_rst during RMW_RD -> all outputs 0 asynchronously. After release, no gpio_we occurs and the next transfer works normally.
